// File: rtl/pc_fetch_unit.sv
// MIPS fetch stage + IF/ID register: 1-cycle pc_f->id_instr latency; stall freezes pc_f, IF/ID and the imem address.
// Optional PFU_ALIGN_CHK_EN: misaligned next-PC redirects to EXC_VECTOR and sets a sticky fetch_err.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  pc_src,
  input  logic        stall,
  input  logic [31:0] rs_data,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus8,
  output logic        id_valid,
  output logic        fetch_err
);

  localparam logic [2:0] PFU_OP_NEXT      = 3'd0;
  localparam logic [2:0] PFU_OP_OFFSET_16 = 3'd1;
  localparam logic [2:0] PFU_OP_OFFSET_26 = 3'd2;
  localparam logic [2:0] PFU_OP_JUMP      = 3'd3;
  localparam logic [2:0] PFU_OP_RS        = 3'd4;

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  state;
  logic [31:0] pc_f;
  logic [31:0] id_pc_plus4;
  logic [31:0] pc_sel;
  logic [31:0] pc_target;
  logic        advance;

  assign id_pc_plus4 = id_pc + 32'd4;
  assign id_pc_plus8 = id_pc + 32'd8;

  // Branch/jump targets come from the instruction already in decode, so the
  // word currently in flight at pc_f becomes the delay slot.
  always_comb begin
    pc_sel = pc_f + 32'd4;
    case (pc_src)
      PFU_OP_NEXT:      pc_sel = pc_f + 32'd4;
      PFU_OP_OFFSET_16: pc_sel = id_pc_plus4 + {{14{id_instr[15]}}, id_instr[15:0], 2'b00};
      PFU_OP_OFFSET_26: pc_sel = id_pc_plus4 + {{4{id_instr[25]}}, id_instr[25:0], 2'b00};
      PFU_OP_JUMP:      pc_sel = {id_pc_plus4[31:28], id_instr[25:0], 2'b00};
      PFU_OP_RS:        pc_sel = rs_data;
      default:          pc_sel = pc_f + 32'd4;
    endcase
  end

  assign advance = (state == ST_RUN) && !stall;

`ifdef PFU_ALIGN_CHK_EN
  logic misaligned;
  assign misaligned = (pc_sel[1:0] != 2'b00);
  assign pc_target  = misaligned ? EXC_VECTOR : pc_sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err <= 1'b0;
    end else if (advance && misaligned) begin
      fetch_err <= 1'b1;
    end
  end
`else
  logic unused_exc_vector;
  assign unused_exc_vector = ^EXC_VECTOR;
  assign pc_target = pc_sel;
  assign fetch_err = 1'b0;
`endif

  // Holding pc_f on the address bus while stalled or booting makes the
  // synchronous memory re-present the same word next cycle.
  assign imem_addr = advance ? pc_target : pc_f;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_BOOT;
      pc_f     <= RESET_PC;
      id_instr <= 32'd0;
      id_pc    <= 32'd0;
      id_valid <= 1'b0;
    end else if (state == ST_BOOT) begin
      state <= ST_RUN;
    end else if (!stall) begin
      pc_f     <= imem_addr;
      id_instr <= imem_rdata;
      id_pc    <= pc_f;
      id_valid <= 1'b1;
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Fetch stage plus IF/ID pipeline register for the MIPS pipeline; sits directly upstream of the decode/control stage.
- Holds the fetch PC, drives the synchronous instruction memory, and latches {instruction, PC} for decode.
- Consumes the PFU_OP_* next-PC select and the stall (pause) signal produced by decode control.
- Computes branch and jump targets from the latched decode-stage instruction. One architectural delay slot: the instruction after a branch or jump is never annulled.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset
- EXC_VECTOR, 32'h0000_4180, redirect address on misaligned target (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_src  in  3 (`PFU_OP_LENGTH)  next-PC select from decode: NEXT=0, OFFSET_16=1, OFFSET_26=2, JUMP=3, RS=4 (`PFU_OP_* in const.vh)
- stall  in  1  decode pause; freezes fetch PC and IF/ID
- rs_data  in  32  forwarded GPR[rs] for jr/jalr
- imem_addr  out  32  instruction memory read address, combinational; data returns on imem_rdata next cycle
- imem_rdata  in  32  instruction word for the address presented last cycle
- id_instr  out  32  latched instruction for decode
- id_pc  out  32  PC of id_instr
- id_pc_plus8  out  32  id_pc+8, link value for jal/jalr
- id_valid  out  1  id_instr holds a fetched instruction (0 = bubble/nop)
- fetch_err  out  1  misaligned-target flag (optional feature; tied 0 otherwise)

Behaviour:
- Reset (async, rst_n=0):
  - pc_f=RESET_PC, state=BOOT.
  - id_instr=0 (sll $0 = nop), id_pc=0, id_valid=0, fetch_err=0.
  - imem_addr=RESET_PC.
- FSM, two states:
  - BOOT: imem_addr=pc_f. IF/ID does not load and id_valid stays 0. Next state RUN unconditionally; stall is ignored in BOOT.
  - RUN: imem_rdata belongs to pc_f. imem_addr=pc_next combinationally.
    - At the clock edge, if !stall: pc_f<=pc_next, id_instr<=imem_rdata, id_pc<=pc_f, id_valid<=1.
    - If stall: all registers hold and pc_next=pc_f, so memory re-reads the same word.
- pc_next in RUN, !stall, selected by pc_src:
  - NEXT: pc_f+4
  - OFFSET_16: id_pc+4+(sext(id_instr[15:0])<<2)
  - OFFSET_26: id_pc+4+(sext(id_instr[25:0])<<2)
  - JUMP: {id_pc_plus4[31:28], id_instr[25:0], 2'b00}
  - RS: rs_data
  - Codes 5..7 are treated as NEXT.
- Stall has priority over pc_src. pc_src is don't-care while stall=1, and a redirect is taken on the first non-stalled cycle.
- Delay slot:
  - The redirect applies to the fetch after the one in flight. The word in pc_f (the delay slot) is still latched into IF/ID.
  - No flush output exists.
- Arithmetic: all adds are 32-bit modulo. 32'hFFFF_FFFC+4 wraps to 0, and negative offsets wrap the same way. No overflow detection.
- Latency: one cycle from pc_f to id_instr. The redirect target appears on imem_addr in the same cycle pc_src is valid.
- Reset mid-operation: rst_n low in any state immediately forces the reset values and returns the FSM to BOOT. A pending stall or redirect is discarded.
- id_pc_plus8 is combinational from id_pc.

Optional Feature:
- Macro PFU_ALIGN_CHK_EN.
- Defined:
  - In RUN, !stall, if the selected pc_next has bits [1:0]!=0, pc_next is replaced by EXC_VECTOR.
  - fetch_err<=1 at that edge. It is sticky until reset.
  - The delay-slot instruction still enters IF/ID.
- Undefined:
  - No check; misaligned targets pass through unchanged.
  - fetch_err is constant 0 and EXC_VECTOR is unused.

Test Plan:
- Reset release with rst_n low for 3 cycles: imem_addr=0x3000 in BOOT; after 2 edges id_pc=0x3000, id_valid=1; then id_pc steps 0x3004, 0x3008 with pc_src=NEXT.
- beq taken: id_pc=0x3010, id_instr[15:0]=0xFFFC, pc_src=1 -> imem_addr=0x3004 that cycle; next id_pc=0x3014 (delay slot); then id_pc=0x3004.
- j: id_pc=0x3020, id_instr[25:0]=0x0000C40, pc_src=3 -> target 0x00003100; jal gives id_pc_plus8=0x3028.
- jr: rs_data=0x0000_3200, pc_src=4 -> imem_addr=0x3200; next IF/ID is the delay slot, and the one after has id_pc=0x3200.
- Stall during branch: stall=1 for 2 cycles with pc_src=1 -> pc_f, id_* and imem_addr held; on release the branch is taken as above.
- With PFU_ALIGN_CHK_EN: jr with rs_data=0x3202 -> imem_addr=0x4180, fetch_err=1 and stays 1. Without the macro: imem_addr=0x3202 and fetch_err=0.
